// File: rtl/ysyx_23060221_icache_pkg.sv
// Shared types and AXI constants for the direct-mapped instruction cache.
package ysyx_23060221_icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_AR,
    ST_MISS_R,
    ST_RESP
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/ysyx_23060221_icache_array.sv
// Valid/tag/data storage: one registered read port, one word-write port,
// a tag+valid write and a whole-array flush of the valid bits.
module ysyx_23060221_icache_array #(
  parameter int NLINES     = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_en,
  input  logic [$clog2(NLINES)-1:0]     rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
  output logic                          rd_valid,
  output logic [TAG_W-1:0]              rd_tag,
  output logic [31:0]                   rd_data,
  input  logic                          wr_en,
  input  logic [$clog2(NLINES)-1:0]     wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
  input  logic [31:0]                   wr_data,
  input  logic                          tag_we,
  input  logic [TAG_W-1:0]              tag_wdata,
  input  logic                          tag_valid,
  input  logic                          flush
);

  logic [31:0]      data_mem [NLINES*LINE_WORDS];
  logic [TAG_W-1:0] tag_mem  [NLINES];
  logic [31:0]      rd_data_q;
  logic [TAG_W-1:0] rd_tag_q;
  logic [NLINES-1:0] valid_q, valid_d;
  logic             rd_valid_q, rd_valid_d;

  // Data and tag RAMs carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[{wr_idx, wr_word}] <= wr_data;
    if (rd_en) rd_data_q <= data_mem[{rd_idx, rd_word}];
  end

  always_ff @(posedge clk) begin
    if (tag_we) tag_mem[wr_idx] <= tag_wdata;
    if (rd_en)  rd_tag_q <= tag_mem[rd_idx];
  end

  // Flush wins over a same-cycle tag write, and the read sees the post-edge view.
  always_comb begin
    valid_d = valid_q;
    if (tag_we) valid_d[wr_idx] = tag_valid;
    if (flush)  valid_d = '0;
    rd_valid_d = rd_valid_q;
    if (rd_en)      rd_valid_d = valid_d[rd_idx];
    else if (flush) rd_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_tag   = rd_tag_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/ysyx_23060221_icache.sv
// Direct-mapped blocking instruction cache between the IFU (AXI slave side)
// and memory (AXI master side, INCR burst line refills).
module ysyx_23060221_icache
  import ysyx_23060221_icache_pkg::*;
#(
  parameter int NLINES     = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        fence_i
);

  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int IDX_W  = $clog2(NLINES);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;
  logic              fence_seen_q, fence_seen_d;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WORD_W-1:0] req_word;
  logic              unused_addr_bits;

  logic              rd_en, rd_valid, wr_en, tag_we, tag_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;

  assign req_idx          = addr_q[OFF_W +: IDX_W];
  assign req_tag          = addr_q[31 -: TAG_W];
  assign req_word         = addr_q[2 +: WORD_W];
  assign unused_addr_bits = ^addr_q[1:0];

  ysyx_23060221_icache_array #(
    .NLINES     (NLINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_idx    (s_araddr[OFF_W +: IDX_W]),
    .rd_word   (s_araddr[2 +: WORD_W]),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_idx    (req_idx),
    .wr_word   (beat_q),
    .wr_data   (m_rdata),
    .tag_we    (tag_we),
    .tag_wdata (req_tag),
    .tag_valid (tag_valid),
    .flush     (fence_i)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    beat_d       = beat_q;
    err_d        = err_q;
    fence_seen_d = fence_seen_q | fence_i;
    s_arready    = 1'b0;
    s_rvalid     = 1'b0;
    m_arvalid    = 1'b0;
    m_rready     = 1'b0;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    tag_we       = 1'b0;
    tag_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_arready = 1'b1;
        // The array read is launched with the handshake so LOOKUP sees it.
        if (s_arvalid) begin
          addr_d  = s_araddr;
          rd_en   = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (rd_valid && (rd_tag == req_tag)) begin
          rdata_d = rd_data;
          resp_d  = RESP_OKAY;
          state_d = ST_RESP;
        end else begin
          beat_d       = '0;
          err_d        = 1'b0;
          fence_seen_d = 1'b0;
          state_d      = ST_MISS_AR;
        end
      end
      ST_MISS_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) state_d = ST_MISS_R;
      end
      ST_MISS_R: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          wr_en  = 1'b1;
          beat_d = beat_q + 1'b1;
          err_d  = err_q | resp_is_err(m_rresp);
          if (beat_q == req_word) rdata_d = m_rdata;
          // A fence anywhere in the burst, including this beat, keeps the line invalid.
          if (m_rlast) begin
            tag_we    = 1'b1;
            tag_valid = !err_d && !fence_seen_d;
            resp_d    = err_d ? RESP_SLVERR : RESP_OKAY;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        s_rvalid = 1'b1;
        if (s_rready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rdata_q      <= '0;
      resp_q       <= RESP_OKAY;
      beat_q       <= '0;
      err_q        <= 1'b0;
      fence_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      fence_seen_q <= fence_seen_d;
    end
  end

  assign s_rdata   = rdata_q;
  assign s_rresp   = resp_q;
  assign s_rlast   = 1'b1;
  assign m_araddr  = {addr_q[31:OFF_W], {OFF_W{1'b0}}};
  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arsize  = SIZE_4B;
  assign m_arburst = BURST_INCR;

endmodule

// File: doc/ysyx_23060221_icache.md
YSYX_23060221_ICACHE -- requirements
Module: ysyx_23060221_icache

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high (clock port clk, reset port rst).
REQ-002 Parameter NLINES, 16, number of direct-mapped lines (power of 2).
REQ-003 Parameter LINE_WORDS, 4, 32-bit words per line (power of 2).
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  async active-high reset.
REQ-006 s_arvalid  in  1  fetch request from IFU.
REQ-007 s_arready  out  1  cache accepts request.
REQ-008 s_araddr  in  32  fetch address, word aligned.
REQ-009 s_rvalid  out  1  instruction valid.
REQ-010 s_rready  in  1  IFU accepts instruction.
REQ-011 s_rdata  out  32  instruction word.
REQ-012 s_rresp  out  2  0 OKAY, 2 SLVERR.
REQ-013 s_rlast  out  1  tied 1.
REQ-014 m_arvalid  out  1  refill request to memory.
REQ-015 m_arready  in  1  memory accepts refill.
REQ-016 m_araddr  out  32  line-aligned refill address.
REQ-017 m_arlen  out  8  LINE_WORDS-1.
REQ-018 m_arsize  out  3  3'b010.
REQ-019 m_arburst  out  2  2'b01 INCR.
REQ-020 m_rvalid  in  1  refill beat valid.
REQ-021 m_rready  out  1  refill beat accepted.
REQ-022 m_rdata  in  32  refill beat data.
REQ-023 m_rresp  in  2  refill beat response.
REQ-024 m_rlast  in  1  last refill beat.
REQ-025 fence_i  in  1  one-cycle pulse: invalidate all lines.

Function
REQ-026 Address split: offset=log2(LINE_WORDS*4) bits, index=log2(NLINES) bits, tag=remaining upper bits.
REQ-027 FSM states: IDLE, LOOKUP, MISS_AR, MISS_R, RESP.
REQ-028 IDLE: s_arready=1; on s_arvalid&s_arready latch address, go LOOKUP.
REQ-029 LOOKUP: hit (valid & tag match) -> RESP with stored word; miss -> MISS_AR; hit latency = 2 cycles from AR handshake to s_rvalid.
REQ-030 MISS_AR: m_arvalid=1, m_araddr=latched address with offset zeroed; on m_arready -> MISS_R.
REQ-031 MISS_R: m_rready=1; beat k written to word k via 2-bit beat counter; requested word captured on its beat.
REQ-032 MISS_R on m_rvalid&m_rlast: set tag; set valid only if every beat had m_rresp==0 and no fence_i arrived since refill start; -> RESP.
REQ-033 Any nonzero m_rresp: s_rresp=2'b10 for that request; line stays invalid.
REQ-034 RESP: s_rvalid held with stable s_rdata/s_rresp until s_rready; then -> IDLE (s_arready rises next cycle).
REQ-035 s_arready=0 in every state except IDLE; at most one outstanding request.
REQ-036 fence_i clears all valid bits next edge in any state; an in-flight request still completes with correct data.
REQ-037 fence_i coincident with refill completion: line left invalid.
REQ-038 m_rlast before LINE_WORDS beats or extra beats: not required; beat counter wraps modulo LINE_WORDS.

Reset
REQ-039 rst asserted: FSM->IDLE, all valid bits 0, beat counter 0, fence flag 0, immediately (asynchronously).
REQ-040 Reset values: s_arready=1 after release; s_rvalid, m_arvalid, m_rready=0; s_rresp=0; data/tag arrays not reset.
REQ-041 rst mid-refill abandons burst; remaining memory beats not consumed after reset.

Structure
REQ-042 Package ysyx_23060221_icache_pkg SHALL hold state enum, AXI resp constants, burst/size constants.
REQ-043 Sub-module ysyx_23060221_icache_array SHALL hold valid/tag/data storage: one read port, one word-write port, tag/valid write, flush.

Verification
REQ-044 Cold fetch 0x80000004 -> one m_ar at 0x80000000, len 3; s_rdata = memory word at 0x80000004.
REQ-045 Refetch 0x80000008 after REQ-044 -> no m_arvalid; s_rvalid 2 cycles after AR handshake.
REQ-046 Fetch 0x80000000 then 0x80000100 (same index) then 0x80000000 -> three refills (conflict eviction).
REQ-047 fence_i after fill, refetch 0x80000000 -> refill issued; fence_i during MISS_R -> next same-line fetch misses.
REQ-048 m_rresp=2 on beat 2 -> s_rresp=2; refetch same line issues new refill.
REQ-049 s_rready low 5 cycles in RESP -> s_rvalid/s_rdata stable; rst mid-MISS_R -> outputs at reset values, next fetch misses.
